// File: rtl/minisys_bus_pkg.sv
// Shared types for the memory/IO bus arbiter: FSM state encoding, default
// widths and the owner encoding used to steer acks and read data.
package minisys_bus_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } bus_state_t;

    // Bit 0 is the CPU ack, bit 1 the loader ack.
    function automatic logic [1:0] owner_onehot(input logic own);
        logic [1:0] oh;
        oh = 2'b00;
        if (own == OWN_LDR) begin
            oh[1] = 1'b1;
        end else begin
            oh[0] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Winner select for the two bus requesters. Define ARB_ROUND_ROBIN_EN to
// alternate on contention; otherwise the CPU has fixed priority.
module arb_pick
    import minisys_bus_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_vld,
    output logic grant_own
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_vld = req0 | req1;
        grant_own = OWN_CPU;
        if (req0 && req1) begin
            // On contention hand the bus to whoever was not served last.
            grant_own = (last_grant == OWN_CPU) ? OWN_LDR : OWN_CPU;
        end else if (req1) begin
            grant_own = OWN_LDR;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant_vld = req0 | req1;
        grant_own = OWN_CPU;
        if (!req0 && req1) begin
            grant_own = OWN_LDR;
        end
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises CPU and loader accesses onto the single memory/IO port.
// Arbitration policy selected by ARB_ROUND_ROBIN_EN (see arb_pick).
module mem_bus_arbiter
    import minisys_bus_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] rdata0,
    output logic              ack0,
    output logic              cpu_stall,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ack1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Counter only has to hold MEM_LAT-1.
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    bus_state_t       state;
    bus_state_t       state_nxt;
    logic             owner;
    logic             last_grant;
    logic             lat_we;
    logic [CNT_W-1:0] cnt;
    logic             rd_sample;
    logic             grant_vld;
    logic             grant_own;

    arb_pick u_arb_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .grant_vld  (grant_vld),
        .grant_own  (grant_own)
    );

    always_comb begin
        state_nxt  = state;
        rd_sample  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        {ack1, ack0} = 2'b00;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_en = 1'b1;
                mem_we = lat_we;
                if (lat_we) begin
                    state_nxt = DONE;
                end else if (MEM_LAT == 1) begin
                    rd_sample = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // Data is captured on the edge that takes the count to zero.
                if (cnt <= CNT_W'(1)) begin
                    rd_sample = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                {ack1, ack0} = owner_onehot(owner);
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_grant <= OWN_LDR;
            lat_we     <= 1'b0;
            cnt        <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            state <= state_nxt;

            // Request is frozen at grant; later input changes are ignored.
            if (state == IDLE && grant_vld) begin
                owner     <= grant_own;
                lat_we    <= (grant_own == OWN_LDR) ? we1    : we0;
                mem_addr  <= (grant_own == OWN_LDR) ? addr1  : addr0;
                mem_wdata <= (grant_own == OWN_LDR) ? wdata1 : wdata0;
            end

            if (state == ISSUE) begin
                cnt <= CNT_W'(MEM_LAT - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (rd_sample) begin
                if (owner == OWN_LDR) begin
                    rdata1 <= mem_rdata;
                end else begin
                    rdata0 <= mem_rdata;
                end
            end

            if (state == DONE) begin
                last_grant <= owner;
            end
        end
    end

    assign cpu_stall = req0 & ~ack0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with MEM_LAT=2: per-cycle vector table
// plus hand sequences for contention, reset abort and dropped requests.
module tb_mem_bus_arbiter;

    logic        clock;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [31:0] rdata0, rdata1;
    logic        ack0, ack1, cpu_stall;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .rdata0    (rdata0),
        .ack0      (ack0),
        .cpu_stall (cpu_stall),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .rdata1    (rdata1),
        .ack1      (ack1),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h20) ? 32'h1234_5678 : (a ^ 32'hA5A5_0000);
    endfunction

    // Read data is presented only in the cycle after the mem_en cycle (MEM_LAT=2).
    always @(posedge clock) begin
        mem_rdata <= (mem_en && !mem_we) ? mem_model(mem_addr) : 32'hBAD0_BAD0;
    end

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        req0;
        logic        we0;
        logic [31:0] addr0;
        logic [31:0] wdata0;
        logic        req1;
        logic        we1;
        logic [31:0] addr1;
        logic [31:0] wdata1;
        logic        en;
        logic        we;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        ack0;
        logic        ack1;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        busy;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    int          n_ack;
    int          n_ack1;
    logic        grants[4];
    logic        exp_grants[4];
    logic        seen_en;
    logic [31:0] seen_addr, seen_wdata;
    logic        got_ack;

    initial begin
        //              rst req0 we0 addr0    wdata0        req1 we1 addr1    wdata1 en we maddr    mwdata        a0 a1 rd0           rd1           busy
        vecs[0]  = '{1'b0, 1, 0, 32'h44, 32'h0,          0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0,          0, 0, 32'h0,         32'h0,         0};
        vecs[1]  = '{1'b0, 1, 0, 32'h44, 32'h0,          0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0,          0, 0, 32'h0,         32'h0,         0};
        vecs[2]  = '{1'b1, 1, 1, 32'h10, 32'hDEADBEEF,   0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0,          0, 0, 32'h0,         32'h0,         0};
        vecs[3]  = '{1'b1, 1, 1, 32'h10, 32'hDEADBEEF,   0, 0, 32'h0,  32'h0, 1, 1, 32'h10, 32'hDEADBEEF,   0, 0, 32'h0,         32'h0,         1};
        vecs[4]  = '{1'b1, 1, 1, 32'h10, 32'hDEADBEEF,   0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0,          1, 0, 32'h0,         32'h0,         1};
        vecs[5]  = '{1'b1, 0, 0, 32'h0,  32'h0,          0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0,          0, 0, 32'h0,         32'h0,         0};
        vecs[6]  = '{1'b1, 1, 0, 32'h20, 32'h0,          0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0,          0, 0, 32'h0,         32'h0,         0};
        vecs[7]  = '{1'b1, 1, 0, 32'h99, 32'h0,          0, 0, 32'h0,  32'h0, 1, 0, 32'h20, 32'h0,          0, 0, 32'h0,         32'h0,         1};
        vecs[8]  = '{1'b1, 1, 0, 32'h99, 32'h0,          0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0,          0, 0, 32'h0,         32'h0,         1};
        vecs[9]  = '{1'b1, 1, 0, 32'h99, 32'h0,          0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0,          1, 0, 32'h12345678,  32'h0,         1};
        vecs[10] = '{1'b1, 0, 0, 32'h0,  32'h0,          0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0,          0, 0, 32'h12345678,  32'h0,         0};
        vecs[11] = '{1'b1, 1, 1, 32'h30, 32'hCAFEF00D,   0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0,          0, 0, 32'h12345678,  32'h0,         0};
        vecs[12] = '{1'b1, 1, 1, 32'h30, 32'hCAFEF00D,   0, 0, 32'h0,  32'h0, 1, 1, 32'h30, 32'hCAFEF00D,   0, 0, 32'h12345678,  32'h0,         1};
        vecs[13] = '{1'b1, 1, 1, 32'h30, 32'hCAFEF00D,   0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0,          1, 0, 32'h12345678,  32'h0,         1};
        vecs[14] = '{1'b1, 0, 0, 32'h0,  32'h0,          0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0,          0, 0, 32'h12345678,  32'h0,         0};
        vecs[15] = '{1'b1, 0, 0, 32'h0,  32'h0,          1, 0, 32'h40, 32'h0, 0, 0, 32'h0,  32'h0,          0, 0, 32'h12345678,  32'h0,         0};
        vecs[16] = '{1'b1, 0, 0, 32'h0,  32'h0,          1, 0, 32'h40, 32'h0, 1, 0, 32'h40, 32'h0,          0, 0, 32'h12345678,  32'h0,         1};
        vecs[17] = '{1'b1, 0, 0, 32'h0,  32'h0,          1, 0, 32'h40, 32'h0, 0, 0, 32'h0,  32'h0,          0, 0, 32'h12345678,  32'h0,         1};
        vecs[18] = '{1'b1, 0, 0, 32'h0,  32'h0,          1, 0, 32'h40, 32'h0, 0, 0, 32'h0,  32'h0,          0, 1, 32'h12345678,  32'hA5A50040,  1};
        vecs[19] = '{1'b1, 0, 0, 32'h0,  32'h0,          0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0,          0, 0, 32'h12345678,  32'hA5A50040,  0};

        reset = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

        // Reset, CPU store, CPU load, write after load, loader load.
        for (int i = 0; i < NV; i++) begin
            next_cycle();
            reset  = vecs[i].rst;
            req0   = vecs[i].req0;   we0 = vecs[i].we0;
            addr0  = vecs[i].addr0;  wdata0 = vecs[i].wdata0;
            req1   = vecs[i].req1;   we1 = vecs[i].we1;
            addr1  = vecs[i].addr1;  wdata1 = vecs[i].wdata1;
            #1;
            chk("mem_en", i, 32'(mem_en), 32'(vecs[i].en));
            chk("mem_we", i, 32'(mem_we), 32'(vecs[i].we));
            chk("ack0",   i, 32'(ack0),   32'(vecs[i].ack0));
            chk("ack1",   i, 32'(ack1),   32'(vecs[i].ack1));
            chk("rdata0", i, rdata0, vecs[i].rd0);
            chk("rdata1", i, rdata1, vecs[i].rd1);
            chk("busy",   i, 32'(busy),   32'(vecs[i].busy));
            if (vecs[i].rst) begin
                chk("cpu_stall", i, 32'(cpu_stall), 32'(vecs[i].req0 & ~vecs[i].ack0));
            end
            if (vecs[i].en) begin
                chk("mem_addr", i, mem_addr, vecs[i].maddr);
            end
            if (vecs[i].en && vecs[i].we) begin
                chk("mem_wdata", i, mem_wdata, vecs[i].mwdata);
            end
        end

        // Contention: both requesters hold their writes for four transactions.
`ifdef ARB_ROUND_ROBIN_EN
        exp_grants = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_grants = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        n_ack  = 0;
        n_ack1 = 0;
        next_cycle();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h100; wdata0 = 32'h1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h200; wdata1 = 32'h2;
        for (int c = 0; c < 40 && n_ack < 4; c++) begin
            next_cycle();
            #1;
            if (ack1) n_ack1++;
            if (ack0 || ack1) begin
                grants[n_ack] = ack1;
                n_ack++;
                if (n_ack == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        chk("contention_acks", -1, 32'(n_ack), 32'd4);
        for (int g = 0; g < 4; g++) begin
            if (g < n_ack) chk("contention_grant", g, 32'(grants[g]), 32'(exp_grants[g]));
        end
`ifndef ARB_ROUND_ROBIN_EN
        chk("fixed_prio_ack1_count", -1, 32'(n_ack1), 32'd0);
`endif
        req0 = 1'b0;
        req1 = 1'b0;
        next_cycle();
        #1;
        chk("contention_idle_busy", -1, 32'(busy), 32'd0);

        // Abort: reset asserted while a CPU read sits in WAIT.
        next_cycle();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
        #1;
        chk("abort_idle_busy", -1, 32'(busy), 32'd0);
        next_cycle();
        #1;
        chk("abort_issue_en", -1, 32'(mem_en), 32'd1);
        next_cycle();
        reset = 1'b0;
        req0  = 1'b0;
        #1;
        chk("abort_wait_busy", -1, 32'(busy), 32'd1);
        next_cycle();
        #1;
        chk("abort_busy", -1, 32'(busy), 32'd0);
        chk("abort_mem_en", -1, 32'(mem_en), 32'd0);
        chk("abort_ack0", -1, 32'(ack0), 32'd0);
        chk("abort_rdata0", -1, rdata0, 32'h0);
        next_cycle();
        reset = 1'b1;
        #1;
        chk("abort_release_ack0", -1, 32'(ack0), 32'd0);
        chk("abort_release_en", -1, 32'(mem_en), 32'd0);

        // A fresh loader store after the abort runs normally.
        next_cycle();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h60; wdata1 = 32'h5A5A_5A5A;
        seen_en = 1'b0; seen_addr = '0; seen_wdata = '0; got_ack = 1'b0;
        for (int c = 0; c < 10 && !got_ack; c++) begin
            next_cycle();
            #1;
            if (mem_en) begin
                seen_en    = 1'b1;
                seen_addr  = mem_addr;
                seen_wdata = mem_wdata;
            end
            if (ack1) begin
                got_ack = 1'b1;
                req1    = 1'b0;
            end
        end
        chk("post_abort_ack1", -1, 32'(got_ack), 32'd1);
        chk("post_abort_en", -1, 32'(seen_en), 32'd1);
        chk("post_abort_addr", -1, seen_addr, 32'h60);
        chk("post_abort_wdata", -1, seen_wdata, 32'h5A5A_5A5A);
        next_cycle();
        #1;
        chk("post_abort_idle", -1, 32'(busy), 32'd0);

        // Drop: loader releases req1 while its read is in WAIT.
        next_cycle();
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h70;
        #1;
        chk("drop_idle_busy", -1, 32'(busy), 32'd0);
        next_cycle();
        #1;
        chk("drop_issue_en", -1, 32'(mem_en), 32'd1);
        next_cycle();
        req1 = 1'b0;
        #1;
        chk("drop_wait_busy", -1, 32'(busy), 32'd1);
        chk("drop_wait_ack1", -1, 32'(ack1), 32'd0);
        next_cycle();
        #1;
        chk("drop_done_ack1", -1, 32'(ack1), 32'd1);
        chk("drop_rdata1", -1, rdata1, 32'hA5A5_0070);
        next_cycle();
        #1;
        chk("drop_after_ack1", -1, 32'(ack1), 32'd0);
        chk("drop_after_busy", -1, 32'(busy), 32'd0);
        next_cycle();
        #1;
        chk("drop_stays_idle", -1, 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected $finish");
        $fatal(1, "watchdog timeout");
    end

endmodule
